prt_vtb_lock: RTL and testbench
===============================

PRT_VTB_LOCK -- requirements
Module: prt_vtb_lock

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high; ports SHALL be as listed in REQ-002..REQ-013 (name  direction  width  meaning).
REQ-002 CLK_IN  input  1  clock; all logic on rising edge.
REQ-003 RST_IN  input  1  synchronous active-high reset.
REQ-004 VID_SOF_IN  input  1  start of frame, qualified by VID_VLD_IN.
REQ-005 VID_VLD_IN  input  1  video valid.
REQ-006 STA_PIX_IN  input  16  measured pixels per line from the video monitor.
REQ-007 STA_LIN_IN  input  16  measured lines per frame from the video monitor.
REQ-008 CTL_EN_IN  input  1  lock detector enable.
REQ-009 CTL_THR_IN  input  4  consecutive matching frames required for lock; 0 SHALL be treated as 1.
REQ-010 CTL_TO_IN  input  24  frame timeout in clocks; 0 SHALL disable the timeout.
REQ-011 LOCK_OUT  output  1  format locked.
REQ-012 LOST_OUT  output  1  one-cycle pulse on loss of lock.
REQ-013 FMT_PIX_OUT / FMT_LIN_OUT  output  16 each  locked pixel/line counts; STA_STATE_OUT  output  2  state (0 IDLE, 1 ACQ, 2 LOCK).

Function
REQ-014 A frame event SHALL be generated 2 clocks after a cycle with VID_SOF_IN && VID_VLD_IN, so that STA_PIX_IN/STA_LIN_IN are sampled once the monitor has updated them.
REQ-015 A sample SHALL be {STA_PIX_IN, STA_LIN_IN} captured on the frame event; a sample with either field 0 SHALL be invalid.
REQ-016 States SHALL be IDLE, ACQ and LOCK.
REQ-017 In any state, CTL_EN_IN=0 SHALL force IDLE next cycle and clear the match counter, reference, timeout counter, LOCK_OUT and FMT outputs.
REQ-018 IDLE SHALL go to ACQ on the cycle after CTL_EN_IN=1 is seen.
REQ-019 In ACQ, on a frame event, a valid sample equal to the reference (per REQ-030) SHALL increment a 4-bit saturating match counter; otherwise the counter SHALL clear and the reference SHALL load the sample.
REQ-020 In ACQ, when the match counter reaches max(CTL_THR_IN,1), the block SHALL go to LOCK. FMT outputs SHALL load the reference and LOCK_OUT SHALL assert, both on the same cycle as the transition.
REQ-021 In LOCK, a frame event with a mismatching or invalid sample SHALL return to ACQ. On that transition the block SHALL pulse LOST_OUT for 1 cycle, deassert LOCK_OUT, clear FMT outputs and the match counter, and load the reference with the sample.
REQ-022 A 24-bit timeout counter SHALL increment every cycle outside IDLE, SHALL clear on every frame event, and SHALL saturate.
REQ-023 When CTL_TO_IN≠0 and the timeout counter equals CTL_TO_IN: in LOCK, the block SHALL behave as in REQ-021 (LOST_OUT pulse, return to ACQ) and the counter SHALL clear; in ACQ, the match counter and reference SHALL clear.
REQ-024 A frame event and a timeout on the same cycle SHALL be resolved in favour of the frame event.
REQ-025 CTL_THR_IN and CTL_TO_IN SHALL be sampled live; a threshold change in ACQ SHALL take effect at the next frame event.
REQ-026 LOST_OUT SHALL never assert in IDLE, including when CTL_EN_IN falls while in LOCK.

Reset
REQ-027 RST_IN SHALL force IDLE and clear all counters and the reference, the 2-stage frame event delay pipe, and every output to 0.
REQ-028 Reset asserted mid-frame or mid-lock SHALL take effect on the next clock edge, with no LOST_OUT pulse.
REQ-029 Operation after reset SHALL resume per REQ-018.

Configuration
REQ-030 Macro PRT_VTB_LOCK_TOLERANCE_EN: when defined, a pixel comparison SHALL match if |STA_PIX_IN − reference| ≤ 2, and lines SHALL still match exactly; when undefined, both fields SHALL match exactly.

Verification
REQ-031 CTL_THR_IN=3, CTL_TO_IN=0, 4 frames of 1920x1080 -> LOCK_OUT=1 at frame event 4, FMT=1920/1080, STA_STATE_OUT=2.
REQ-032 Locked at 1920x1080, next frame 1280x720 -> LOST_OUT 1-cycle pulse, STA_STATE_OUT=1, LOCK_OUT=0, relock after 3 further 1280x720 frames.
REQ-033 Locked, CTL_TO_IN=1000, SOF withheld -> LOST_OUT pulse exactly 1000 clocks after the last frame event; SOF arriving on the timeout cycle -> no loss.
REQ-034 Locked, 1920 then 1922 pixels -> loss without PRT_VTB_LOCK_TOLERANCE_EN; lock retained with it; 1924 -> loss in both builds.
REQ-035 Locked, CTL_EN_IN=0 -> IDLE next cycle, all outputs 0, no LOST_OUT; RST_IN mid-lock -> same.
REQ-036 CTL_THR_IN=0, sample sequence 0x1080 then two frames of 1920x1080 -> invalid first sample ignored, LOCK_OUT=1 on the second valid matching frame.

Source files
------------

// File: rtl/prt_vtb_lock.sv
// Video format lock detector: a frame rate / size monitor with timeout loss.
// Optional macro PRT_VTB_LOCK_TOLERANCE_EN allows +/-2 pixel slack per line.
module prt_vtb_lock (
   input  logic        CLK_IN,
   input  logic        RST_IN,
   input  logic        VID_SOF_IN,
   input  logic        VID_VLD_IN,
   input  logic [15:0] STA_PIX_IN,
   input  logic [15:0] STA_LIN_IN,
   input  logic        CTL_EN_IN,
   input  logic [3:0]  CTL_THR_IN,
   input  logic [23:0] CTL_TO_IN,
   output logic        LOCK_OUT,
   output logic        LOST_OUT,
   output logic [15:0] FMT_PIX_OUT,
   output logic [15:0] FMT_LIN_OUT,
   output logic [1:0]  STA_STATE_OUT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_sof_d;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [15:0] r_ref_pix, w_ref_pix_nxt;
   logic [15:0] r_ref_lin, w_ref_lin_nxt;
   logic [23:0] r_to, w_to_nxt;
   logic        r_lock, w_lock_nxt;
   logic        r_lost, w_lost_nxt;
   logic [15:0] r_fmt_pix, w_fmt_pix_nxt;
   logic [15:0] r_fmt_lin, w_fmt_lin_nxt;

   logic        w_fev;
   logic        w_valid;
   logic        w_pix_eq;
   logic        w_match;
   logic [3:0]  w_thr;
   logic [3:0]  w_cnt_inc;
   logic [23:0] w_to_inc;
   logic        w_to_hit;

   // Two-cycle delay lets the monitor publish the finished frame's counts
   assign w_fev = r_sof_d[1];

   assign w_valid = (STA_PIX_IN != 16'd0) && (STA_LIN_IN != 16'd0);

`ifdef PRT_VTB_LOCK_TOLERANCE_EN
   logic [15:0] w_pix_dif;
   assign w_pix_dif = (STA_PIX_IN >= r_ref_pix) ? (STA_PIX_IN - r_ref_pix)
                                                : (r_ref_pix - STA_PIX_IN);
   assign w_pix_eq  = (w_pix_dif <= 16'd2);
`else
   assign w_pix_eq  = (STA_PIX_IN == r_ref_pix);
`endif

   assign w_match   = w_valid && (r_ref_pix != 16'd0) && w_pix_eq
                      && (STA_LIN_IN == r_ref_lin);
   assign w_thr     = (CTL_THR_IN == 4'd0) ? 4'd1 : CTL_THR_IN;
   assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
   assign w_to_inc  = (&r_to) ? r_to : r_to + 24'd1;
   // Fires on the cycle the counter reaches the programmed value
   assign w_to_hit  = (CTL_TO_IN != 24'd0) && (w_to_inc == CTL_TO_IN);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_ref_pix_nxt = r_ref_pix;
      w_ref_lin_nxt = r_ref_lin;
      w_to_nxt      = r_to;
      w_lock_nxt    = r_lock;
      w_lost_nxt    = 1'b0;
      w_fmt_pix_nxt = r_fmt_pix;
      w_fmt_lin_nxt = r_fmt_lin;
      if (!CTL_EN_IN) begin
         w_state_nxt   = ST_IDLE;
         w_cnt_nxt     = 4'd0;
         w_ref_pix_nxt = 16'd0;
         w_ref_lin_nxt = 16'd0;
         w_to_nxt      = 24'd0;
         w_lock_nxt    = 1'b0;
         w_fmt_pix_nxt = 16'd0;
         w_fmt_lin_nxt = 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ACQ;
               w_to_nxt    = 24'd0;
            end
            ST_ACQ: begin
               w_to_nxt = w_to_inc;
               if (w_fev) begin
                  w_to_nxt = 24'd0;
                  if (w_match) begin
                     w_cnt_nxt = w_cnt_inc;
                     if (w_cnt_inc >= w_thr) begin
                        w_state_nxt   = ST_LOCK;
                        w_lock_nxt    = 1'b1;
                        w_fmt_pix_nxt = r_ref_pix;
                        w_fmt_lin_nxt = r_ref_lin;
                     end
                  end else begin
                     w_cnt_nxt     = 4'd0;
                     w_ref_pix_nxt = STA_PIX_IN;
                     w_ref_lin_nxt = STA_LIN_IN;
                  end
               end else if (w_to_hit) begin
                  w_cnt_nxt     = 4'd0;
                  w_ref_pix_nxt = 16'd0;
                  w_ref_lin_nxt = 16'd0;
               end
            end
            ST_LOCK: begin
               w_to_nxt = w_to_inc;
               if ((w_fev && !w_match) || (!w_fev && w_to_hit)) begin
                  w_state_nxt   = ST_ACQ;
                  w_lost_nxt    = 1'b1;
                  w_lock_nxt    = 1'b0;
                  w_fmt_pix_nxt = 16'd0;
                  w_fmt_lin_nxt = 16'd0;
                  w_cnt_nxt     = 4'd0;
                  w_to_nxt      = 24'd0;
                  w_ref_pix_nxt = w_fev ? STA_PIX_IN : 16'd0;
                  w_ref_lin_nxt = w_fev ? STA_LIN_IN : 16'd0;
               end else if (w_fev) begin
                  w_to_nxt = 24'd0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_state   <= ST_IDLE;
         r_sof_d   <= 2'b00;
         r_cnt     <= 4'd0;
         r_ref_pix <= 16'd0;
         r_ref_lin <= 16'd0;
         r_to      <= 24'd0;
         r_lock    <= 1'b0;
         r_lost    <= 1'b0;
         r_fmt_pix <= 16'd0;
         r_fmt_lin <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_sof_d   <= {r_sof_d[0], VID_SOF_IN & VID_VLD_IN};
         r_cnt     <= w_cnt_nxt;
         r_ref_pix <= w_ref_pix_nxt;
         r_ref_lin <= w_ref_lin_nxt;
         r_to      <= w_to_nxt;
         r_lock    <= w_lock_nxt;
         r_lost    <= w_lost_nxt;
         r_fmt_pix <= w_fmt_pix_nxt;
         r_fmt_lin <= w_fmt_lin_nxt;
      end
   end

   assign LOCK_OUT      = r_lock;
   assign LOST_OUT      = r_lost;
   assign FMT_PIX_OUT   = r_fmt_pix;
   assign FMT_LIN_OUT   = r_fmt_lin;
   assign STA_STATE_OUT = r_state;

endmodule

// File: tb/tb_prt_vtb_lock.sv
// Directed bench for prt_vtb_lock: lock, loss, timeout, tolerance, enable
// and reset, with hand-computed expectations.
module tb_prt_vtb_lock;

   logic        clk = 1'b0;
   logic        rst;
   logic        sof;
   logic        vld;
   logic [15:0] pix;
   logic [15:0] lin;
   logic        en;
   logic [3:0]  thr;
   logic [23:0] tmo;
   logic        lock;
   logic        lost;
   logic [15:0] fpix;
   logic [15:0] flin;
   logic [1:0]  st;

   int n_tot = 0;
   int n_bad = 0;

   prt_vtb_lock dut (
      .CLK_IN        (clk),
      .RST_IN        (rst),
      .VID_SOF_IN    (sof),
      .VID_VLD_IN    (vld),
      .STA_PIX_IN    (pix),
      .STA_LIN_IN    (lin),
      .CTL_EN_IN     (en),
      .CTL_THR_IN    (thr),
      .CTL_TO_IN     (tmo),
      .LOCK_OUT      (lock),
      .LOST_OUT      (lost),
      .FMT_PIX_OUT   (fpix),
      .FMT_LIN_OUT   (flin),
      .STA_STATE_OUT (st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge after the frame event edge
   task automatic frame(input logic [15:0] p, input logic [15:0] l);
      pix = p;
      lin = l;
      sof = 1'b1;
      vld = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic relock(input logic [15:0] p, input logic [15:0] l,
                         input int n);
      for (int i = 0; i < n; i++) frame(p, l);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; sof = 1'b0; vld = 1'b0; pix = '0; lin = '0;
      en = 1'b0; thr = 4'd3; tmo = 24'd0;
      repeat (3) @(negedge clk);
      chk("rst_state", st, 0);
      chk("rst_lock", lock, 0);
      chk("rst_lost", lost, 0);
      chk("rst_fpix", fpix, 0);
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      chk("en_acq", st, 1);

      relock(16'd1920, 16'd1080, 3);
      chk("f3_lock", lock, 0);
      chk("f3_state", st, 1);
      frame(16'd1920, 16'd1080);
      chk("f4_lock", lock, 1);
      chk("f4_fpix", fpix, 1920);
      chk("f4_flin", flin, 1080);
      chk("f4_state", st, 2);

      frame(16'd1280, 16'd720);
      chk("chg_lost", lost, 1);
      chk("chg_state", st, 1);
      chk("chg_lock", lock, 0);
      chk("chg_fpix", fpix, 0);
      @(negedge clk);
      chk("chg_pulse", lost, 0);
      relock(16'd1280, 16'd720, 2);
      chk("r2_lock", lock, 0);
      frame(16'd1280, 16'd720);
      chk("r3_lock", lock, 1);
      chk("r3_fpix", fpix, 1280);
      chk("r3_flin", flin, 720);

      relock(16'd1920, 16'd1080, 4);
      chk("back_lock", lock, 1);

      tmo = 24'd1000;
      frame(16'd1920, 16'd1080);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!lost && n < 1100);
      chk("to_dly", n, 1000);
      chk("to_state", st, 1);
      chk("to_lock", lock, 0);

      relock(16'd1920, 16'd1080, 4);
      chk("to_relock", lock, 1);
      repeat (997) @(negedge clk);
      frame(16'd1920, 16'd1080);
      chk("tie_lost", lost, 0);
      chk("tie_lock", lock, 1);
      @(negedge clk);
      chk("tie_lost2", lost, 0);
      chk("tie_state", st, 2);
      tmo = 24'd0;

      frame(16'd1922, 16'd1080);
`ifdef PRT_VTB_LOCK_TOLERANCE_EN
      chk("tol2_lost", lost, 0);
      chk("tol2_lock", lock, 1);
`else
      chk("tol2_lost", lost, 1);
      chk("tol2_lock", lock, 0);
`endif
      relock(16'd1920, 16'd1080, 4);
      chk("tol_relock", lock, 1);
      frame(16'd1924, 16'd1080);
      chk("tol4_lost", lost, 1);
      chk("tol4_state", st, 1);

      relock(16'd1920, 16'd1080, 4);
      chk("pre_en_lock", lock, 1);
      en = 1'b0;
      @(negedge clk);
      chk("dis_state", st, 0);
      chk("dis_lock", lock, 0);
      chk("dis_lost", lost, 0);
      chk("dis_fpix", fpix, 0);
      chk("dis_flin", flin, 0);
      en = 1'b1;
      @(negedge clk);
      chk("reen_state", st, 1);

      relock(16'd1920, 16'd1080, 4);
      chk("pre_rst_lock", lock, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_state", st, 0);
      chk("mrst_lock", lock, 0);
      chk("mrst_lost", lost, 0);
      chk("mrst_fpix", fpix, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_acq", st, 1);
      chk("mrst_lost2", lost, 0);

      thr = 4'd0;
      frame(16'd0, 16'd1080);
      chk("inv_lock", lock, 0);
      frame(16'd1920, 16'd1080);
      chk("v1_lock", lock, 0);
      frame(16'd1920, 16'd1080);
      chk("v2_lock", lock, 1);
      chk("v2_state", st, 2);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
